// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - transmitter and receiver state encodings
//   - even-parity helper (word is zero-extended to MAX_DATA_BITS)
//   - default bit period for the 12 MHz board clock at 9600 baud
package uart_pkg;

   localparam int DEFAULT_BAUD_DIV = 1250;  // 12 MHz / 9600 baud
   localparam int MAX_DATA_BITS    = 9;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   // Receiver-side naming, kept here so both ends agree on frame phases.
   typedef enum logic [1:0] {
      RX_WAIT,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART transmitter.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   clear    in  restart the bit period (count returns to 0 next cycle)
//   tick     out high in the last clock of each BAUD_DIV-clock bit period
//   pre_tick out high in the clock before tick, so the FSM can register
//                outputs that must be valid during the last clock
module uart_baud_tick #(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam logic [15:0] LAST_CNT = 16'(BAUD_DIV - 1);
   localparam logic [15:0] PRE_CNT  = 16'(BAUD_DIV - 2);

   logic [15:0] cnt_q, cnt_d;

   assign tick     = (cnt_q == LAST_CNT);
   assign pre_tick = (cnt_q == PRE_CNT);

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (clear || tick) cnt_d = 16'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 16'd0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. One word per valid/ready handshake, sent as
// start bit, LSB-first data, optional even parity, one stop bit, each bit
// BAUD_DIV clocks long.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   valid   in  data_in holds a word to send
//   data_in in  word to transmit (latched on accept)
//   ready   out word can be accepted this cycle (IDLE or final stop clock)
//   tx      out serial line, idle high, driven from a flop
//   done    out one-cycle pulse in the final clock of the stop bit
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV      = 434,
   parameter int DATA_BITS     = 8,
   parameter int ENABLE_PARITY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 ready,
   output logic                 tx,
   output logic                 done
);

   localparam int            BCW      = $clog2(DATA_BITS) + 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   tx_state_e            state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [BCW-1:0]       bit_cnt_q;
   logic                 par_q;
   logic                 tx_q;
   logic                 ready_q;
   logic                 done_q;

   logic accept;
   logic tick;
   logic pre_tick;
   logic baud_clear;
   logic data_par;

   assign accept   = valid && ready_q;
   assign data_par = even_parity(MAX_DATA_BITS'(data_in));

   // Hold the timer at zero while idle so every frame starts a fresh period.
   assign baud_clear = (state_q == TX_IDLE) || accept;

   uart_baud_tick #(
      .BAUD_DIV(BAUD_DIV)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (baud_clear),
      .tick    (tick),
      .pre_tick(pre_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= TX_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            TX_IDLE: begin
               if (accept) begin
                  shift_q <= data_in;
                  par_q   <= data_par;
                  tx_q    <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tick) begin
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= '0;
                  state_q   <= TX_DATA;
               end
            end
            TX_DATA: begin
               // bit_cnt_q counts data bits already completed on the line
               if (tick) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     if (ENABLE_PARITY != 0) begin
                        tx_q    <= par_q;
                        state_q <= TX_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= TX_STOP;
                     end
                  end else begin
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            TX_PARITY: begin
               if (tick) begin
                  tx_q    <= 1'b1;
                  state_q <= TX_STOP;
               end
            end
            TX_STOP: begin
               // Raise ready/done one clock early so both are flops that
               // cover exactly the final stop clock.
               if (pre_tick) begin
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
               if (tick) begin
                  if (accept) begin
                     // Back-to-back: next start bit with no idle gap.
                     shift_q <= data_in;
                     par_q   <= data_par;
                     tx_q    <= 1'b0;
                     ready_q <= 1'b0;
                     state_q <= TX_START;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end
            end
            default: begin
               state_q <= TX_IDLE;
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign tx    = tx_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic       valid;
   logic [7:0] data_in;
   logic       ready, tx, done;

   logic       valid2;
   logic [6:0] data2;
   logic       ready2, tx2, done2;

   int checks = 0;
   int errors = 0;

   logic tx_s [0:127];
   logic dn_s [0:127];
   logic rd_s [0:127];

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;
   vec_t vecs [6];

   uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(1)) dut (
      .clk(clk), .rst(rst), .valid(valid), .data_in(data_in),
      .ready(ready), .tx(tx), .done(done)
   );

   uart_tx #(.BAUD_DIV(3), .DATA_BITS(7), .ENABLE_PARITY(0)) dut2 (
      .clk(clk), .rst(rst), .valid(valid2), .data_in(data2),
      .ready(ready2), .tx(tx2), .done(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk({nm, " ready timeout"}, 64'(ready), 64'd1);
   endtask

   // Accept d at the next edge; returns at the negedge of the first start clock.
   task automatic start_frame(input logic [7:0] d, input string nm);
      wait_ready(nm);
      valid   = 1'b1;
      data_in = d;
      @(posedge clk);
      @(negedge clk);
      valid   = 1'b0;
      data_in = ~d;
   endtask

   task automatic capture(input int off, input int n);
      for (int i = 0; i < n; i++) begin
         tx_s[off+i] = tx;
         dn_s[off+i] = done;
         rd_s[off+i] = ready;
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input int off, input logic [7:0] d, input logic par,
                              input string nm);
      logic [10:0] eb;
      logic [3:0]  got;
      logic [63:0] dv, rv;
      eb = {1'b1, par, d, 1'b0};
      for (int k = 0; k < 11; k++) begin
         got = {tx_s[off+4*k+3], tx_s[off+4*k+2], tx_s[off+4*k+1], tx_s[off+4*k]};
         chk($sformatf("%s bit%0d", nm, k), 64'(got), {60'd0, {4{eb[k]}}});
      end
      dv = '0;
      rv = '0;
      for (int i = 0; i < 44; i++) begin
         dv[i] = dn_s[off+i];
         rv[i] = rd_s[off+i];
      end
      chk({nm, " done"}, dv, 64'd1 << 43);
      chk({nm, " ready"}, rv, 64'd1 << 43);
   endtask

   task automatic run_dut2(input logic [6:0] d, input string nm);
      logic [8:0]  eb;
      logic [2:0]  got;
      logic        t [0:26];
      logic [63:0] dv;
      int n = 0;
      while (ready2 !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk({nm, " ready timeout"}, 64'(ready2), 64'd1);
      valid2 = 1'b1;
      data2  = d;
      @(posedge clk);
      @(negedge clk);
      valid2 = 1'b0;
      data2  = ~d;
      dv = '0;
      for (int i = 0; i < 27; i++) begin
         t[i]  = tx2;
         dv[i] = done2;
         @(negedge clk);
      end
      eb = {1'b1, d, 1'b0};
      for (int k = 0; k < 9; k++) begin
         got = {t[3*k+2], t[3*k+1], t[3*k]};
         chk($sformatf("%s bit%0d", nm, k), 64'(got), {61'd0, {3{eb[k]}}});
      end
      chk({nm, " done"}, dv, 64'd1 << 26);
   endtask

   initial begin
      logic [63:0] acc;

      vecs[0] = '{8'hA5, 1'b0};
      vecs[1] = '{8'h01, 1'b1};
      vecs[2] = '{8'h00, 1'b0};
      vecs[3] = '{8'hFF, 1'b0};
      vecs[4] = '{8'h80, 1'b1};
      vecs[5] = '{8'h7F, 1'b1};

      // Reset asserted together with valid: reset wins, nothing accepted.
      rst = 1'b1; valid = 1'b1; data_in = 8'h00; valid2 = 1'b0; data2 = '0;
      repeat (3) @(negedge clk);
      chk("reset tx", 64'(tx), 64'd1);
      chk("reset ready", 64'(ready), 64'd1);
      chk("reset done", 64'(done), 64'd0);
      chk("reset tx2", 64'(tx2), 64'd1);
      rst = 1'b0; valid = 1'b0;
      acc = '0;
      for (int i = 0; i < 10; i++) begin
         acc[i] = tx;
         @(negedge clk);
      end
      chk("rst+valid no frame", acc, 64'h3FF);

      // Table-driven single frames.
      foreach (vecs[v]) begin
         start_frame(vecs[v].data, "vec");
         capture(0, 44);
         check_frame(0, vecs[v].data, vecs[v].par, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d idle tx", v), 64'(tx), 64'd1);
         chk($sformatf("vec%0d idle ready", v), 64'(ready), 64'd1);
      end

      // Back-to-back: valid held, 0x55 then 0xAA with no idle gap.
      start_frame(8'h55, "b2b");
      valid = 1'b1; data_in = 8'hAA;
      capture(0, 44);
      valid = 1'b0; data_in = 8'h00;
      capture(44, 44);
      check_frame(0, 8'h55, 1'b0, "b2b f0");
      check_frame(44, 8'hAA, 1'b0, "b2b f1");
      chk("b2b idle tx", 64'(tx), 64'd1);

      // valid pulsed with 0x3C mid-frame is ignored.
      start_frame(8'hA5, "ign");
      capture(0, 10);
      valid = 1'b1; data_in = 8'h3C;
      capture(10, 1);
      valid = 1'b0;
      capture(11, 33);
      check_frame(0, 8'hA5, 1'b0, "ign");
      acc = '0;
      for (int i = 0; i < 20; i++) begin
         acc[i] = tx;
         @(negedge clk);
      end
      chk("ign stays idle", acc, 64'hFFFFF);

      // Reset during data bit 3 (cycles 16..19 after accept).
      start_frame(8'hC3, "rst");
      capture(0, 17);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst tx", 64'(tx), 64'd1);
      chk("midrst ready", 64'(ready), 64'd1);
      acc = '0;
      for (int i = 0; i < 50; i++) begin
         if (done === 1'b1 || tx !== 1'b1) acc = acc + 1;
         @(negedge clk);
      end
      chk("midrst quiet", acc, 64'd0);
      start_frame(8'h81, "post");
      capture(0, 44);
      check_frame(0, 8'h81, 1'b0, "post81");

      // 7 data bits, no parity.
      run_dut2(7'h5A, "d7 5A");
      run_dut2(7'h01, "d7 01");
      run_dut2(7'h7F, "d7 7F");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
